hdmi_tmds_channel: RTL
======================

// Module: hdmi_tmds_channel
// PURPOSE
// One HDMI TMDS lane encoder for HDMI 1.4 transmission, replacing DVI-only encoding. Per cycle it emits one 10-bit symbol chosen by i_mode:
//   video (8b/10b, DC-balanced), control, TERC4 data island, video guard band or data guard band.
// A period-sequence checker flags illegal mode ordering. Three instances, CHANNEL=0..2, feed the OSER10 serializers in the hdmi top.
// PARAMETERS
// CHANNEL   0  lane index 0..2; selects the guard-band codes and the ch0 data-guard TERC4 form
// LATENCY   2  input-to-o_tmds cycles, legal values 1 or 2 (2 = pipeline register between q_m stage and output)
// PORTS
// i_hdmi_clk   in   1   pixel clock
// i_reset_n    in   1   asynchronous active-low reset
// i_mode       in   3   0=CTRL 1=VIDEO 2=ISLAND 3=VGB 4=DGB; 5..7 illegal, treated as CTRL
// i_data       in   8   video pixel component, used in VIDEO mode
// i_ctrl       in   2   {c1,c0}, used in CTRL mode; in DGB mode on ch0 = {vsync,hsync}
// i_terc4      in   4   data-island nibble, used in ISLAND mode
// i_err_clr    in   1   synchronous clear of o_seq_err
// o_tmds       out  10  encoded symbol; bit 0 is transmitted first
// o_seq_err    out  1   sticky mode-sequence violation flag
// BEHAVIOUR
// - Reset (async assert, sync release): o_tmds=10'b1101010100 (CTRL 00); bias=0; o_seq_err=0; all pipeline registers
//   hold CTRL/00; checker FSM=S_CTRL.
// - Latency: o_tmds reflects inputs sampled LATENCY rising edges earlier. i_mode is delayed alongside the data.
// - VIDEO: standard DVI 1.0 algorithm.
//   - Stage 1: N1(i_data); XNOR path if N1>4 or (N1==4 and d[0]==0); q_m[8]=1 for the XOR path.
//   - Output stage: signed 5-bit bias cnt. If cnt==0 or N1(q_m)==N0(q_m):
//     o=={~q_m8,q_m8,q_m8?q_m:~q_m}, cnt+=q_m8?(N1-N0):(N0-N1).
//   - Else if (cnt>0&&N1>N0)||(cnt<0&&N0>N1): o={1,q_m8,~q_m}, cnt+=2*q_m8+N0-N1.
//   - Else: o={0,q_m8,q_m}, cnt+=N1-N0-2*~q_m8.
//   - All arithmetic is 5-bit two's complement; |cnt|<=10 is never exceeded.
// - CTRL: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (o_tmds[9:0]).
// - ISLAND: TERC4 table lookup of i_terc4.
// - VGB: CHANNEL 0,2 ->1011001100; CHANNEL 1 ->0100110011.
// - DGB: CHANNEL 1,2 ->0100110011; CHANNEL 0 ->TERC4({1,1,i_ctrl}).
// - Bias is cleared to 0 on every non-VIDEO output cycle. It holds its value only across consecutive VIDEO cycles.
// - Checker FSM runs on the input stage, one transition per cycle.
//   - States: S_CTRL, S_VGB1, S_VGB2, S_VID, S_DGBL1, S_DGBL2, S_ISL, S_DGBT1, S_DGBT2.
//   - Video path: CTRL->VGB1->VGB2->VID; VID->VID; VID->CTRL.
//   - Island path: CTRL->DGBL1->DGBL2->ISL; ISL->ISL; ISL->DGBT1->DGBT2->CTRL.
//   - CTRL->CTRL is legal.
//   - Any other mode sequence sets o_seq_err (registered, visible next cycle). The FSM then resyncs to the state
//     implied by the current mode: VIDEO->S_VID, ISLAND->S_ISL, VGB->S_VGB1, DGB->S_DGBL1, else S_CTRL.
//   - Encoding is never suppressed by an error.
// - Preamble length is not checked; that belongs to the timing generator.
// - i_err_clr and a same-cycle violation occurring together: the error wins and o_seq_err stays 1.
// - Reset mid-stream: o_tmds reverts to CTRL 00 immediately (async), and bias restarts from 0.
// STRUCTURE
// - Package hdmi_pkg holds:
//   - typedef enum logic[2:0] tmds_mode_e.
//   - localparam CTRL_CODE[4], TERC4_CODE[16], VGB_CODE[3], DGB_CODE_C12.
//   - FSM state enum.
// - Sub-module tmds_video_qm (combinational + optional register): computes q_m[8:0] and N1-N0 of q_m. The output stage
//   and checker live in hdmi_tmds_channel.
// - TERC4 (q_out[9:0]), 0..F: 1010011100 1001100011 1011100100 1011100010 0101110001 0100011110 0110001110 0100111100
//   1011001100 0100111001 0110011100 1011000111 1010001110 1001110001 0101100011 1011000011
// TESTING
// - Reset then VIDEO 8'h00 x3 -> o_tmds 0100000000, 1111111111, 0100000000; bias -8, +2, -6.
// - CTRL with i_ctrl=0..3 -> the four control codes above after LATENCY cycles; bias reads 0 afterwards.
// - CHANNEL=0: DGB,DGB,ISLAND(i_terc4=0..F),DGB,DGB with i_ctrl=2'b01.
//   -> guard symbol TERC4(4'hD)=1001110001 and the 16 table codes in order; o_seq_err stays 0.
// - CTRL->VGB->VIDEO (only one guard cycle) -> o_seq_err=1 next cycle. i_err_clr pulse -> 0. Video output still encoded.
// - Random 10k-cycle video stream checked against a DVI reference model.
//   -> o_tmds matches; running disparity stays within +/-10; each symbol decodes back to i_data.
// - Assert i_reset_n=0 mid-VIDEO -> o_tmds=1101010100 in the same cycle without a clock; first VIDEO symbol after release
//   is encoded with bias 0.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and symbol tables for the HDMI TMDS lane encoder.
package hdmi_pkg;

  typedef enum logic [2:0] {
    TM_CTRL   = 3'd0,
    TM_VIDEO  = 3'd1,
    TM_ISLAND = 3'd2,
    TM_VGB    = 3'd3,
    TM_DGB    = 3'd4
  } tmds_mode_e;

  typedef enum logic [3:0] {
    S_CTRL, S_VGB1, S_VGB2, S_VID, S_DGBL1, S_DGBL2, S_ISL, S_DGBT1, S_DGBT2
  } seq_state_e;

  // Non-video symbol travelling alongside q_m through the optional pipeline stage
  typedef struct packed {
    tmds_mode_e mode;
    logic [9:0] sym;
  } stage_t;

  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] VGB_CODE [3] = '{
    10'b1011001100, 10'b0100110011, 10'b1011001100
  };

  localparam logic [9:0] DGB_CODE_C12 = 10'b0100110011;

  // Codes 5..7 are not defined and fall back to control periods
  function automatic tmds_mode_e decode_mode(input logic [2:0] m);
    tmds_mode_e r;
    case (m)
      3'd1:    r = TM_VIDEO;
      3'd2:    r = TM_ISLAND;
      3'd3:    r = TM_VGB;
      3'd4:    r = TM_DGB;
      default: r = TM_CTRL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hdmi_tmds_channel_if.sv
// Per-lane symbol request/response bundle between timing generator and TMDS encoder.
interface hdmi_tmds_channel_if;
  logic [2:0] i_mode;
  logic [7:0] i_data;
  logic [1:0] i_ctrl;
  logic [3:0] i_terc4;
  logic       i_err_clr;
  logic [9:0] o_tmds;
  logic       o_seq_err;

  modport master (
    output i_mode, i_data, i_ctrl, i_terc4, i_err_clr,
    input  o_tmds, o_seq_err
  );

  modport slave (
    input  i_mode, i_data, i_ctrl, i_terc4, i_err_clr,
    output o_tmds, o_seq_err
  );
endinterface

// File: rtl/tmds_video_qm.sv
// DVI stage 1: transition-minimised q_m[8:0] plus the signed ones/zeros imbalance of q_m[7:0].
module tmds_video_qm #(
  parameter bit REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        data_i,
  output logic [8:0]        qm_o,
  output logic signed [4:0] diff_o
);

  logic [3:0]        n1_d;
  logic [3:0]        ones_d;
  logic              use_xnor;
  logic [8:0]        qm_d;
  logic signed [4:0] diff_d;

  always_comb begin
    n1_d   = '0;
    ones_d = '0;
    qm_d   = '0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, data_i[i]};
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data_i[0]);
    qm_d[0] = data_i[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
    qm_d[8] = ~use_xnor;
    for (int i = 0; i < 8; i++) ones_d = ones_d + {3'b000, qm_d[i]};
    // N1 - N0 = 2*N1 - 8, always within -8..+8
    diff_d = $signed({ones_d, 1'b0} - 5'd8);
  end

  if (REG) begin : g_reg
    logic [8:0]        qm_q;
    logic signed [4:0] diff_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        qm_q   <= '0;
        diff_q <= '0;
      end else begin
        qm_q   <= qm_d;
        diff_q <= diff_d;
      end
    end
    assign qm_o   = qm_q;
    assign diff_o = diff_q;
  end else begin : g_comb
    assign qm_o   = qm_d;
    assign diff_o = diff_d;
  end

endmodule

// File: rtl/hdmi_tmds_channel.sv
// One HDMI 1.4 TMDS lane: video 8b/10b, control, TERC4 island and guard-band symbols,
// plus a checker that flags illegal period ordering.
module hdmi_tmds_channel
  import hdmi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int LATENCY = 2
) (
  input  logic               i_hdmi_clk,
  input  logic               i_reset_n,
  hdmi_tmds_channel_if.slave bus
);

  localparam bit         PIPE    = (LATENCY == 2);
  localparam logic [9:0] VGB_SYM = VGB_CODE[CHANNEL];

  tmds_mode_e mode_in;
  stage_t     st_in, st;

  always_comb begin
    mode_in     = decode_mode(bus.i_mode);
    st_in.mode  = mode_in;
    st_in.sym   = CTRL_CODE[bus.i_ctrl];
    case (mode_in)
      TM_ISLAND: st_in.sym = TERC4_CODE[bus.i_terc4];
      TM_VGB:    st_in.sym = VGB_SYM;
      // Lane 0 carries hsync/vsync inside the data guard band
      TM_DGB:    st_in.sym = (CHANNEL == 0) ? TERC4_CODE[{2'b11, bus.i_ctrl}] : DGB_CODE_C12;
      default:   ;
    endcase
  end

  if (PIPE) begin : g_pipe
    stage_t st_q;
    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
      if (!i_reset_n) st_q <= '{mode: TM_CTRL, sym: CTRL_CODE[0]};
      else            st_q <= st_in;
    end
    assign st = st_q;
  end else begin : g_comb
    assign st = st_in;
  end

  logic [8:0]        qm;
  logic signed [4:0] qm_diff;

  tmds_video_qm #(.REG(PIPE)) u_qm (
    .clk_i   (i_hdmi_clk),
    .rst_n_i (i_reset_n),
    .data_i  (bus.i_data),
    .qm_o    (qm),
    .diff_o  (qm_diff)
  );

  // Output stage: DC-balancing with a running disparity that only survives across VIDEO
  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] cnt_d, cnt_q;

  always_comb begin
    tmds_d = st.sym;
    cnt_d  = '0;
    if (st.mode == TM_VIDEO) begin
      if ((cnt_q == 5'sd0) || (qm_diff == 5'sd0)) begin
        tmds_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_d  = qm[8] ? (cnt_q + qm_diff) : (cnt_q - qm_diff);
      end else if (((cnt_q > 5'sd0) && (qm_diff > 5'sd0)) ||
                   ((cnt_q < 5'sd0) && (qm_diff < 5'sd0))) begin
        tmds_d = {1'b1, qm[8], ~qm[7:0]};
        cnt_d  = cnt_q + $signed({3'b000, qm[8], 1'b0}) - qm_diff;
      end else begin
        tmds_d = {1'b0, qm[8], qm[7:0]};
        cnt_d  = cnt_q + qm_diff - $signed({3'b000, ~qm[8], 1'b0});
      end
    end
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmds_q <= CTRL_CODE[0];
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.o_tmds = tmds_q;

  // Period-sequence checker on the raw input stage
  seq_state_e state_q, state_d;
  logic       err_q, err_d, viol;

  always_comb begin
    state_d = state_q;
    viol    = 1'b0;
    case (state_q)
      S_CTRL: begin
        if (mode_in == TM_VGB)       state_d = S_VGB1;
        else if (mode_in == TM_DGB)  state_d = S_DGBL1;
        else if (mode_in != TM_CTRL) viol    = 1'b1;
      end
      S_VGB1:  if (mode_in == TM_VGB)    state_d = S_VGB2;  else viol = 1'b1;
      S_VGB2:  if (mode_in == TM_VIDEO)  state_d = S_VID;   else viol = 1'b1;
      S_VID: begin
        if (mode_in == TM_CTRL)       state_d = S_CTRL;
        else if (mode_in != TM_VIDEO) viol    = 1'b1;
      end
      S_DGBL1: if (mode_in == TM_DGB)    state_d = S_DGBL2; else viol = 1'b1;
      S_DGBL2: if (mode_in == TM_ISLAND) state_d = S_ISL;   else viol = 1'b1;
      S_ISL: begin
        if (mode_in == TM_DGB)         state_d = S_DGBT1;
        else if (mode_in != TM_ISLAND) viol    = 1'b1;
      end
      S_DGBT1: if (mode_in == TM_DGB)    state_d = S_DGBT2; else viol = 1'b1;
      S_DGBT2: if (mode_in == TM_CTRL)   state_d = S_CTRL;  else viol = 1'b1;
      default: viol = 1'b1;
    endcase
    if (viol) begin
      case (mode_in)
        TM_VIDEO:  state_d = S_VID;
        TM_ISLAND: state_d = S_ISL;
        TM_VGB:    state_d = S_VGB1;
        TM_DGB:    state_d = S_DGBL1;
        default:   state_d = S_CTRL;
      endcase
    end
    // A violation in the clear cycle keeps the flag set
    err_d = viol ? 1'b1 : (bus.i_err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_CTRL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_seq_err = err_q;

endmodule
